// File: rtl/shift_unit_pipe_if.sv
// Request/result handshake bundle for shift_unit_pipe.
// The master drives requests and result-ready; the slave (the shifter) drives the rest.
interface shift_unit_pipe_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_data;
  logic [XLEN-1:0]  in_shamt;
  logic [1:0]       in_op;
  logic             in_word;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_shamt, in_op, in_word, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, in_word, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter: SLL / SRL / SRA / ROR with optional 32-bit word mode.
// Every operation is reduced to a right shift or right rotate: SLL bit-reverses the
// operand on entry and again on exit. The log2(XLEN) mux levels are split across
// STAGES registers; the last stage register is the output register.
module shift_unit_pipe #(
  parameter int XLEN   = 64,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input logic              clk,
  input logic              rst,
  shift_unit_pipe_if.slave bus
);

  localparam int LVLS = $clog2(XLEN);
  localparam int LPS  = (LVLS + STAGES - 1) / STAGES;  // mux levels per stage

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  data;   // partial result (final result in the last stage)
    logic [LVLS-1:0]  amt;    // masked shift amount; each stage consumes its own bits
    op_e              op;
    logic             word;
    logic             fill;   // bit shifted in from the MSB side (SRA sign, else 0)
    logic [TAG_W-1:0] tag;
  } stage_t;

  stage_t stg_q [STAGES];
  stage_t stg_d [STAGES];
  stage_t src   [STAGES];
  stage_t entry;
  logic   advance;
  logic   unused_shamt;

  function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] x);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) r[i] = x[XLEN-1-i];
    return r;
  endfunction

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
    logic [XLEN-1:0] r;
    r       = {XLEN{x[31]}};
    r[31:0] = x;
    return r;
  endfunction

  // Apply mux levels lo..hi-1 (shift by 1,2,4,...) selected by the amount bits.
  function automatic logic [XLEN-1:0] run_levels(input stage_t s, input int lo, input int hi);
    logic [XLEN-1:0] d;
    d = s.data;
    for (int i = 0; i < LVLS; i++) begin
      if (i >= lo && i < hi && s.amt[i]) begin
        if (s.op == OP_ROR)
          d = (d >> (1 << i)) | (d << (XLEN - (1 << i)));
        else
          d = (d >> (1 << i)) | ({XLEN{s.fill}} & ~({XLEN{1'b1}} >> (1 << i)));
      end
    end
    return d;
  endfunction

  // The pipeline moves as a whole whenever the output slot is empty or being drained.
  assign advance = !stg_q[STAGES-1].valid || bus.out_ready;

  // Only the low shift-amount bits matter; the rest are deliberately dropped.
  assign unused_shamt = ^bus.in_shamt;

  // Entry formatting: choose operand view, fill bit and masked amount.
  // In word mode a rotate works on the operand replicated across the datapath,
  // so the low 32 bits of a wide rotate equal the 32-bit rotate.
  always_comb begin
    logic        word;
    logic [31:0] w32;
    logic [XLEN-1:0] opnd;
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    entry = '0;
    word  = (XLEN > 32) ? bus.in_word : 1'b0;
    w32   = bus.in_data[31:0];
    opnd  = bus.in_data;
    if (word) begin
      case (op_e'(bus.in_op))
        OP_SRA:  opnd = sext32(w32);
        OP_ROR:  opnd = {(XLEN/32){w32}};
        default: opnd = XLEN'(w32);
      endcase
    end
    entry.valid = bus.in_valid;
    entry.op    = op_e'(bus.in_op);
    entry.word  = word;
    entry.tag   = bus.in_tag;
    entry.fill  = (entry.op == OP_SRA) && (word ? w32[31] : bus.in_data[XLEN-1]);
    entry.amt   = word ? LVLS'(bus.in_shamt[4:0]) : bus.in_shamt[LVLS-1:0];
    entry.data  = (entry.op == OP_SLL) ? bit_rev(opnd) : opnd;
  end

  // Per-stage next state: each stage applies its share of mux levels; the last
  // stage also undoes the SLL reversal and sign-extends word results.
  always_comb begin
    src[0] = entry;
    for (int k = 1; k < STAGES; k++) src[k] = stg_q[k-1];
    for (int k = 0; k < STAGES; k++) begin
      stg_d[k]      = src[k];
      stg_d[k].data = run_levels(src[k], k * LPS, (k + 1) * LPS);
      if (k == STAGES - 1) begin
        if (src[k].op == OP_SLL) stg_d[k].data = bit_rev(stg_d[k].data);
        if (src[k].word)         stg_d[k].data = sext32(stg_d[k].data[31:0]);
      end
    end
  end

  // Stage registers: all move together on advance, all hold otherwise.
  // NOTE: data and tag are reset too (not only valid) because the output register
  // must read as zero while reset is asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) stg_q[k] <= '0;
    end else if (advance) begin
      // NOTE: non-blocking assignment so every stage samples its predecessor's old value.
      for (int k = 0; k < STAGES; k++) stg_q[k] <= stg_d[k];
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = stg_q[STAGES-1].valid;
  assign bus.out_data  = stg_q[STAGES-1].data;
  assign bus.out_tag   = stg_q[STAGES-1].tag;

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Bench for shift_unit_pipe: five instances (XLEN/STAGES variants) share one stimulus
// stream; each has its own scoreboard fed by a plain-arithmetic reference model.
module tb_shift_unit_pipe;

  localparam int N_DUT = 5;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_data;
  logic [63:0] in_shamt;
  logic [1:0]  in_op;
  logic        in_word;
  logic [3:0]  in_tag;
  logic [N_DUT-1:0]        rdy;
  logic [N_DUT-1:0]        m_in_ready;
  logic [N_DUT-1:0]        m_out_valid;
  logic [N_DUT-1:0][63:0]  m_out_data;
  logic [N_DUT-1:0][3:0]   m_out_tag;
  logic        drain_chk;
  logic        bp_collect;
  logic [3:0]  got_tags[$];

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int stg_of(input int g);
    case (g)
      0: return 2;
      1: return 1;
      2: return 3;
      3: return 6;
      default: return 2;
    endcase
  endfunction

  function automatic int xlen_of(input int g);
    return (g == 4) ? 32 : 64;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain shifts on an n-bit value, n = 32 in word mode else XLEN.
  function automatic logic [63:0] ref_shift(input int xl, input logic [63:0] d,
                                            input logic [63:0] sh, input logic [1:0] op,
                                            input logic w);
    int          n;
    int          a;
    logic [63:0] m;
    logic [63:0] v;
    logic [63:0] r;
    if (xl == 32) w = 1'b0;
    n = w ? 32 : xl;
    m = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    v = d & m;
    a = int'(sh % 64'(n));
    case (op)
      2'd0: r = (v << a) & m;
      2'd1: r = v >> a;
      2'd2: begin
        r = v >> a;
        if (v[n-1]) r = r | (m & ~(m >> a));
      end
      default: r = ((v >> a) | (v << (n - a))) & m;
    endcase
    if (w && r[31]) r = r | 64'hFFFF_FFFF_0000_0000;
    return r;
  endfunction

  for (genvar g = 0; g < N_DUT; g++) begin : u
    localparam int XW = xlen_of(g);
    localparam int SG = stg_of(g);

    shift_unit_pipe_if #(.XLEN(XW), .TAG_W(4)) bus ();

    assign bus.in_valid  = in_valid;
    assign bus.in_data   = XW'(in_data);
    assign bus.in_shamt  = XW'(in_shamt);
    assign bus.in_op     = in_op;
    assign bus.in_word   = in_word;
    assign bus.in_tag    = in_tag;
    assign bus.out_ready = rdy[g];
    assign m_in_ready[g]  = bus.in_ready;
    assign m_out_valid[g] = bus.out_valid;
    assign m_out_data[g]  = 64'(bus.out_data);
    assign m_out_tag[g]   = bus.out_tag;

    shift_unit_pipe #(.XLEN(XW), .STAGES(SG), .TAG_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );

    typedef struct {
      logic [63:0] data;
      logic [3:0]  tag;
    } exp_t;
    exp_t        q[$];
    exp_t        e;
    logic        hold_v = 1'b0;
    logic [63:0] hold_d;
    logic [3:0]  hold_t;
    logic        drained = 1'b0;

    // Scoreboard, sampled mid-cycle where handshake values are settled.
    always @(negedge clk) begin
      if (rst) begin
        q.delete();
        hold_v = 1'b0;
      end else begin
        if (hold_v && bus.out_valid) begin
          check($sformatf("u%0d.stall_data", g), m_out_data[g], hold_d);
          check($sformatf("u%0d.stall_tag", g), 64'(bus.out_tag), 64'(hold_t));
        end
        if (bus.out_valid && rdy[g]) begin
          check($sformatf("u%0d.sb_has_entry", g), 64'(q.size() > 0), 64'd1);
          if (q.size() > 0) begin
            e = q.pop_front();
            check($sformatf("u%0d.sb_data", g), m_out_data[g], e.data);
            check($sformatf("u%0d.sb_tag", g), 64'(bus.out_tag), 64'(e.tag));
          end
        end
        if (in_valid && bus.in_ready)
          q.push_back('{ref_shift(XW, in_data, in_shamt, in_op, in_word), in_tag});
        hold_v = bus.out_valid && !rdy[g];
        hold_d = m_out_data[g];
        hold_t = bus.out_tag;
        if (drain_chk && !drained) begin
          drained = 1'b1;
          check($sformatf("u%0d.drain_empty", g), 64'(q.size()), 64'd0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bp_collect && !rst && m_out_valid[0] && rdy[0]) got_tags.push_back(m_out_tag[0]);
  end

  typedef struct {
    logic [63:0] data;
    logic [63:0] shamt;
    logic [1:0]  op;
    logic        word;
    logic [63:0] exp64;
    logic [63:0] exp32;
  } vec_t;

  vec_t vecs[$];

  // One request, then watch every instance for exactly one result at its latency.
  task automatic run_vec(input vec_t v, input int idx);
    logic exp_v;
    in_valid = 1'b1;
    in_data  = v.data;
    in_shamt = v.shamt;
    in_op    = v.op;
    in_word  = v.word;
    in_tag   = 4'(idx);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int e = 0; e < 7; e++) begin
      for (int g = 0; g < N_DUT; g++) begin
        exp_v = (e == stg_of(g) - 1);
        check($sformatf("vec%0d.u%0d.valid@%0d", idx, g, e), 64'(m_out_valid[g]), 64'(exp_v));
        if (exp_v)
          check($sformatf("vec%0d.u%0d.data", idx, g), m_out_data[g],
                (g == 4) ? v.exp32 : v.exp64);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic drive_random();
    in_data  = {$urandom, $urandom};
    in_shamt = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 70)) : {$urandom, $urandom};
    in_op    = 2'($urandom_range(0, 3));
    in_word  = 1'($urandom_range(0, 1));
  endtask

  initial begin
    int   tag;
    int   budget;
    logic acc;
    int   seen_new;
    int   seen_stale;

    in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0; in_word = 1'b0; in_tag = '0;
    rdy = '1; drain_chk = 1'b0; bp_collect = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    for (int g = 0; g < N_DUT; g++) begin
      check($sformatf("rst.u%0d.out_valid", g), 64'(m_out_valid[g]), 64'd0);
      check($sformatf("rst.u%0d.out_data", g), m_out_data[g], 64'd0);
      check($sformatf("rst.u%0d.out_tag", g), 64'(m_out_tag[g]), 64'd0);
      check($sformatf("rst.u%0d.in_ready", g), 64'(m_in_ready[g]), 64'd1);
    end

    //               data                   shamt  op  w  exp64                  exp32
    vecs.push_back('{64'h8000000000000000, 64'd0,  2, 0, 64'h8000000000000000, 64'h0});
    vecs.push_back('{64'h8000000000000000, 64'd1,  2, 0, 64'hC000000000000000, 64'h0});
    vecs.push_back('{64'h8000000000000000, 64'd4,  2, 0, 64'hF800000000000000, 64'h0});
    vecs.push_back('{64'h8000000000000000, 64'd13, 2, 0, 64'hFFFC000000000000, 64'h0});
    vecs.push_back('{64'h8000000000000000, 64'd32, 2, 0, 64'hFFFFFFFF80000000, 64'h0});
    vecs.push_back('{64'h8000000000000000, 64'd63, 2, 0, 64'hFFFFFFFFFFFFFFFF, 64'h0});
    vecs.push_back('{64'h8000000000000000, 64'd65, 2, 0, 64'hC000000000000000, 64'h0});
    vecs.push_back('{64'hA0A0A0A0A0A0A0A0, 64'd4,  0, 0, 64'h0A0A0A0A0A0A0A00, 64'h0A0A0A00});
    vecs.push_back('{64'hA0A0A0A0A0A0A0A0, 64'd4,  1, 0, 64'h0A0A0A0A0A0A0A0A, 64'h0A0A0A0A});
    vecs.push_back('{64'hA0A0A0A0A0A0A0A0, 64'd4,  2, 0, 64'hFA0A0A0A0A0A0A0A, 64'hFA0A0A0A});
    vecs.push_back('{64'hA0A0A0A0A0A0A0A0, 64'd4,  3, 0, 64'h0A0A0A0A0A0A0A0A, 64'h0A0A0A0A});
    vecs.push_back('{64'h0000000080000000, 64'd1,  2, 1, 64'hFFFFFFFFC0000000, 64'hC0000000});
    vecs.push_back('{64'hFFFFFFFF00000001, 64'd33, 0, 1, 64'h0000000000000002, 64'h00000002});
    vecs.push_back('{64'h0000000000000001, 64'd1,  3, 1, 64'hFFFFFFFF80000000, 64'h80000000});
    vecs.push_back('{64'h0000000080000000, 64'd0,  2, 1, 64'hFFFFFFFF80000000, 64'h80000000});
    vecs.push_back('{64'h0000000080000000, 64'd13, 2, 1, 64'hFFFFFFFFFFFC0000, 64'hFFFC0000});
    vecs.push_back('{64'h0000000080000000, 64'd32, 2, 1, 64'hFFFFFFFF80000000, 64'h80000000});
    vecs.push_back('{64'h0000000080000000, 64'd63, 2, 1, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF});
    vecs.push_back('{64'h0000000000000001, 64'd63, 0, 0, 64'h8000000000000000, 64'h80000000});
    vecs.push_back('{64'h8000000000000000, 64'd127,1, 0, 64'h0000000000000001, 64'h0});
    vecs.push_back('{64'h123456789ABCDEF0, 64'd0,  3, 0, 64'h123456789ABCDEF0, 64'h9ABCDEF0});
    vecs.push_back('{64'h123456789ABCDEF0, 64'd68, 3, 0, 64'h0123456789ABCDEF, 64'h09ABCDEF});

    // Release reset; the very next edge must accept the first vector.
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Backpressure: tags 0..7 back to back, main instance's out_ready toggling.
    bp_collect = 1'b1;
    tag    = 0;
    budget = 0;
    while (tag < 8 && budget < 300) begin
      rdy[0]   = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      in_tag   = 4'(tag);
      if (budget == 0 || acc) drive_random();
      @(negedge clk);
      acc = in_valid && m_in_ready[0];
      @(posedge clk); #1;
      if (acc) tag++;
      budget++;
    end
    check("bp.issue_timeout", 64'(tag), 64'd8);
    in_valid = 1'b0;
    budget   = 0;
    while (got_tags.size() < 8 && budget < 100) begin
      rdy[0] = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      budget++;
    end
    rdy[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bp_collect = 1'b0;
    check("bp.count", 64'(got_tags.size()), 64'd8);
    for (int i = 0; i < got_tags.size() && i < 8; i++)
      check($sformatf("bp.order%0d", i), 64'(got_tags[i]), 64'(i));

    // Random traffic with random stalls on the main instance.
    for (int c = 0; c < 400; c++) begin
      rdy[0]   = ($urandom_range(0, 2) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_tag   = 4'($urandom);
      drive_random();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rdy = '1;
    repeat (8) @(posedge clk);
    #1;

    // Reset with two operations in flight.
    in_valid = 1'b1; in_data = 64'h00000000DEADBEEF; in_shamt = 64'd3; in_op = 2'd1;
    in_word = 1'b0; in_tag = 4'd9;
    @(posedge clk); #1;
    in_tag = 4'd10; in_shamt = 64'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rstmid.in_flight", 64'(m_out_valid[0]), 64'd1);
    rst = 1'b1;
    #1;
    for (int g = 0; g < N_DUT; g++) begin
      check($sformatf("rstmid.u%0d.out_valid", g), 64'(m_out_valid[g]), 64'd0);
      check($sformatf("rstmid.u%0d.out_data", g), m_out_data[g], 64'd0);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b1; in_data = 64'h0F0F0F0F0F0F0F0F; in_shamt = 64'd8; in_op = 2'd0;
    in_word = 1'b0; in_tag = 4'd11;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen_new   = 0;
    seen_stale = 0;
    for (int c = 0; c < 8; c++) begin
      if (m_out_valid[0]) begin
        if (m_out_tag[0] == 4'd11) seen_new++;
        else seen_stale++;
        if (m_out_tag[0] == 4'd11)
          check("rstmid.new_data", m_out_data[0], 64'h0F0F0F0F0F0F0F00);
      end
      @(posedge clk); #1;
    end
    check("rstmid.new_seen", 64'(seen_new), 64'd1);
    check("rstmid.stale_seen", 64'(seen_stale), 64'd0);

    repeat (10) @(posedge clk);
    drain_chk = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
